// File: rtl/branch_predictor_table.sv
// branch_predictor_table: pattern history table of saturating counters for
// the IF-stage conditional branch prediction. The table is indexed by the fetch
// PC, optionally hashed with a global history (gshare). It is trained by the ID
// stage and also counts resolved and mispredicted branches.
module branch_predictor_table #(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int HIST_LEN = 6,
  parameter int GSHARE   = 1,
  localparam int IDX     = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    IF_pc,
  input  logic                IF_Branch,
  output logic                prediction,
  output logic [IDX-1:0]      pred_index,
  input  logic                upd_en,
  input  logic [IDX-1:0]      upd_index,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  output logic [HIST_LEN-1:0] ghr,
  output logic [WIDTH-1:0]    branch_cnt,
  output logic [WIDTH-1:0]    miss_cnt
);

  // Weakly not-taken. This value is 0 for 1-bit counters.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [WIDTH-1:0]    CNT_ONE  = WIDTH'(1);

  logic [CTR_BITS-1:0] pht_q [ENTRIES];
  logic [HIST_LEN-1:0] ghr_q, ghr_d, ghr_shift;
  logic [WIDTH-1:0]    branch_cnt_q, branch_cnt_d;
  logic [WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CTR_BITS-1:0] ctr_cur, ctr_d;
  logic [IDX-1:0]      pc_idx;

  // Word-aligned PC: the low two bits never select an entry. Bits above the
  // index are not part of the lookup.
  assign pc_idx = IF_pc[IDX+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^IF_pc;

  // ---------------------------------------------------------------------------
  // Lookup: combinational from the registered table and history. There is no
  // bypass from a same-cycle update.
  // ---------------------------------------------------------------------------
  if (GSHARE != 0) begin : g_gshare
    logic [IDX-1:0] hist_idx;
    if (HIST_LEN == IDX) begin : g_hist_full
      assign hist_idx = ghr_q;
    end else begin : g_hist_pad
      assign hist_idx = {{(IDX - HIST_LEN){1'b0}}, ghr_q};
    end
    assign pred_index = pc_idx ^ hist_idx;
  end else begin : g_bimodal
    assign pred_index = pc_idx;
  end

  assign prediction = IF_Branch & pht_q[pred_index][CTR_BITS-1];

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  assign ctr_cur = pht_q[upd_index];

  // Saturating step of the counter being trained.
  always_comb begin
    ctr_d = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) begin
        ctr_d = ctr_cur + CTR_ONE;
      end
    end else begin
      if (ctr_cur != '0) begin
        ctr_d = ctr_cur - CTR_ONE;
      end
    end
  end

  // The history shifts in the resolved outcome. A 1-bit history just holds it.
  if (HIST_LEN == 1) begin : g_hist_one
    assign ghr_shift = upd_taken;
  end else begin : g_hist_multi
    assign ghr_shift = {ghr_q[HIST_LEN-2:0], upd_taken};
  end

  // Next state for the history and the performance counters. The mispredict
  // flag only counts when a branch actually resolves.
  always_comb begin
    ghr_d        = ghr_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (upd_en) begin
      ghr_d        = ghr_shift;
      branch_cnt_d = branch_cnt_q + CNT_ONE;
      if (upd_mispredict) begin
        miss_cnt_d = miss_cnt_q + CNT_ONE;
      end
    end
  end

  // PHT register array: reset clears the whole table in one cycle and takes
  // priority over a concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else if (upd_en) begin
      pht_q[upd_index] <= ctr_d;
    end
  end

  // History and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q        <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign ghr        = ghr_q;
  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: a bimodal instance, a gshare instance and
// a narrow WIDTH=4 instance driven from a vector table and a few sequences.
module tb_branch_predictor_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // bimodal instance (GSHARE=0)
  logic [31:0] b_pc;  logic b_br, b_pred; logic [5:0] b_idx;
  logic b_ue; logic [5:0] b_ui; logic b_ut, b_um;
  logic [5:0] b_ghr; logic [31:0] b_bc, b_mc;
  // gshare instance
  logic [31:0] g_pc;  logic g_br, g_pred; logic [5:0] g_idx;
  logic g_ue; logic [5:0] g_ui; logic g_ut, g_um;
  logic [5:0] g_ghr; logic [31:0] g_bc, g_mc;
  // narrow instance: WIDTH=4, ENTRIES=4, CTR_BITS=1, HIST_LEN=2, gshare
  logic [3:0] s_pc;  logic s_br, s_pred; logic [1:0] s_idx;
  logic s_ue; logic [1:0] s_ui; logic s_ut, s_um;
  logic [1:0] s_ghr; logic [3:0] s_bc, s_mc;

  branch_predictor_table #(.WIDTH(32), .ENTRIES(64), .CTR_BITS(2), .HIST_LEN(6), .GSHARE(0)) u_bim (
    .clk(clk), .rst(rst), .IF_pc(b_pc), .IF_Branch(b_br), .prediction(b_pred),
    .pred_index(b_idx), .upd_en(b_ue), .upd_index(b_ui), .upd_taken(b_ut),
    .upd_mispredict(b_um), .ghr(b_ghr), .branch_cnt(b_bc), .miss_cnt(b_mc));

  branch_predictor_table #(.WIDTH(32), .ENTRIES(64), .CTR_BITS(2), .HIST_LEN(6), .GSHARE(1)) u_gsh (
    .clk(clk), .rst(rst), .IF_pc(g_pc), .IF_Branch(g_br), .prediction(g_pred),
    .pred_index(g_idx), .upd_en(g_ue), .upd_index(g_ui), .upd_taken(g_ut),
    .upd_mispredict(g_um), .ghr(g_ghr), .branch_cnt(g_bc), .miss_cnt(g_mc));

  branch_predictor_table #(.WIDTH(4), .ENTRIES(4), .CTR_BITS(1), .HIST_LEN(2), .GSHARE(1)) u_small (
    .clk(clk), .rst(rst), .IF_pc(s_pc), .IF_Branch(s_br), .prediction(s_pred),
    .pred_index(s_idx), .upd_en(s_ue), .upd_index(s_ui), .upd_taken(s_ut),
    .upd_mispredict(s_um), .ghr(s_ghr), .branch_cnt(s_bc), .miss_cnt(s_mc));

  typedef struct {
    bit          dut;
    logic [31:0] pc;
    logic        br, ue;
    logic [5:0]  ui;
    logic        ut, um;
    logic        pred;
    logic [5:0]  idx, ghr;
    logic [31:0] bc, mc;
  } vec_t;

  typedef struct {
    int          row;
    bit          dut;
    logic        pred;
    logic [5:0]  idx, ghr;
    logic [31:0] bc, mc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int total, bad;

  function automatic vec_t mk(bit dut, logic [31:0] pc, logic br, logic ue, logic [5:0] ui,
                              logic ut, logic um, logic pred, logic [5:0] idx,
                              logic [5:0] ghr, logic [31:0] bc, logic [31:0] mc);
    vec_t v;
    v.dut = dut; v.pc = pc; v.br = br; v.ue = ue; v.ui = ui; v.ut = ut; v.um = um;
    v.pred = pred; v.idx = idx; v.ghr = ghr; v.bc = bc; v.mc = mc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b_ue = 1'b0; b_um = 1'b0; b_ut = 1'b0;
    g_ue = 1'b0; g_um = 1'b0; g_ut = 1'b0;
    s_ue = 1'b0; s_um = 1'b0; s_ut = 1'b0;
  endtask

  task automatic set_b(input logic [31:0] pc, input logic br, input logic ue,
                       input logic [5:0] ui, input logic ut, input logic um);
    b_pc = pc; b_br = br; b_ue = ue; b_ui = ui; b_ut = ut; b_um = um;
  endtask

  // Drive one vector and push what its lookup and registered state must show.
  task automatic drive(input vec_t v, input int row);
    exp_t e;
    if (!v.dut) begin
      b_pc = v.pc; b_br = v.br; b_ue = v.ue; b_ui = v.ui; b_ut = v.ut; b_um = v.um;
    end else begin
      g_pc = v.pc; g_br = v.br; g_ue = v.ue; g_ui = v.ui; g_ut = v.ut; g_um = v.um;
    end
    e.row = row; e.dut = v.dut; e.pred = v.pred; e.idx = v.idx;
    e.ghr = v.ghr; e.bc = v.bc; e.mc = v.mc;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: no expected entry, got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    if (!e.dut) begin
      chk($sformatf("row%0d pred", e.row), 32'(b_pred), 32'(e.pred));
      chk($sformatf("row%0d idx", e.row),  32'(b_idx),  32'(e.idx));
      chk($sformatf("row%0d ghr", e.row),  32'(b_ghr),  32'(e.ghr));
      chk($sformatf("row%0d bcnt", e.row), b_bc, e.bc);
      chk($sformatf("row%0d mcnt", e.row), b_mc, e.mc);
    end else begin
      chk($sformatf("row%0d pred", e.row), 32'(g_pred), 32'(e.pred));
      chk($sformatf("row%0d idx", e.row),  32'(g_idx),  32'(e.idx));
      chk($sformatf("row%0d ghr", e.row),  32'(g_ghr),  32'(e.ghr));
      chk($sformatf("row%0d bcnt", e.row), g_bc, e.bc);
      chk($sformatf("row%0d mcnt", e.row), g_mc, e.mc);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Each row: outputs seen in the cycle it is driven; its update lands at the next edge.
    //               dut pc            br ue ui     ut um   pred idx    ghr    bc  mc
    // bimodal: reset state, saturation up/down, IF_Branch gating
    vecs.push_back(mk(0, 32'h0000_0040, 1, 0, 6'h00, 0, 0,  0, 6'h10, 6'h00,  0, 0));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 1, 0,  0, 6'h10, 6'h00,  0, 0));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 1, 0,  1, 6'h10, 6'h01,  1, 0));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 1, 0,  1, 6'h10, 6'h03,  2, 0));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 1, 0,  1, 6'h10, 6'h07,  3, 0));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 0, 1,  1, 6'h10, 6'h0F,  4, 0));
    vecs.push_back(mk(0, 32'h0000_0040, 0, 0, 6'h00, 0, 0,  0, 6'h10, 6'h1E,  5, 1));
    vecs.push_back(mk(0, 32'hFFFF_FF43, 1, 1, 6'h10, 0, 1,  1, 6'h10, 6'h1E,  5, 1));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 0, 0,  0, 6'h10, 6'h3C,  6, 2));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 0, 0,  0, 6'h10, 6'h38,  7, 2));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 0, 0,  0, 6'h10, 6'h30,  8, 2));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 1, 0,  0, 6'h10, 6'h20,  9, 2));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 1, 6'h10, 1, 0,  0, 6'h10, 6'h01, 10, 2));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 0, 6'h00, 0, 0,  1, 6'h10, 6'h03, 11, 2));
    // bimodal: same-cycle lookup/update at 0x17, mispredict without upd_en
    vecs.push_back(mk(0, 32'h0000_005C, 1, 1, 6'h17, 1, 1,  0, 6'h17, 6'h03, 11, 2));
    vecs.push_back(mk(0, 32'h0000_005C, 1, 0, 6'h00, 0, 0,  1, 6'h17, 6'h07, 12, 3));
    vecs.push_back(mk(0, 32'h0000_00FC, 1, 0, 6'h00, 0, 1,  0, 6'h3F, 6'h07, 12, 3));
    vecs.push_back(mk(0, 32'h0000_005C, 1, 0, 6'h00, 0, 1,  1, 6'h17, 6'h07, 12, 3));
    vecs.push_back(mk(0, 32'h0000_0040, 1, 0, 6'h00, 0, 0,  1, 6'h10, 6'h07, 12, 3));
    // gshare: history hash and same-cycle hazard with a moving history
    vecs.push_back(mk(1, 32'h0000_0040, 1, 0, 6'h00, 0, 0,  0, 6'h10, 6'h00,  0, 0));
    vecs.push_back(mk(1, 32'h0000_0000, 1, 1, 6'h00, 1, 0,  0, 6'h00, 6'h00,  0, 0));
    vecs.push_back(mk(1, 32'h0000_0000, 1, 1, 6'h00, 1, 0,  0, 6'h01, 6'h01,  1, 0));
    vecs.push_back(mk(1, 32'h0000_0000, 1, 1, 6'h00, 1, 0,  0, 6'h03, 6'h03,  2, 0));
    vecs.push_back(mk(1, 32'h0000_0040, 1, 1, 6'h00, 0, 1,  0, 6'h17, 6'h07,  3, 0));
    vecs.push_back(mk(1, 32'h0000_0040, 1, 0, 6'h00, 0, 0,  0, 6'h1E, 6'h0E,  4, 1));
    vecs.push_back(mk(1, 32'h0000_0038, 1, 0, 6'h00, 0, 0,  1, 6'h00, 6'h0E,  4, 1));
    vecs.push_back(mk(1, 32'h0000_0064, 1, 1, 6'h17, 1, 0,  0, 6'h17, 6'h0E,  4, 1));
    vecs.push_back(mk(1, 32'h0000_0028, 1, 0, 6'h00, 0, 0,  1, 6'h17, 6'h1D,  5, 1));

    // reset, with an update asserted that must be ignored
    rst = 1'b1;
    set_b(32'h40, 1'b1, 1'b1, 6'h10, 1'b1, 1'b1);
    g_pc = 32'h40; g_br = 1'b1; g_ue = 1'b1; g_ui = 6'h10; g_ut = 1'b1; g_um = 1'b1;
    s_pc = 4'h4; s_br = 1'b1; s_ue = 1'b1; s_ui = 2'd1; s_ut = 1'b1; s_um = 1'b1;
    tick();
    rst = 1'b0;
    idle_all();

    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      idle_all();
      drive(vecs[i], i);
      #3;
      compare();
    end

    // reset mid-training: 0x10 is at 2, history non-zero
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_all();
      set_b(32'h40, 1'b1, 1'b1, 6'h10, 1'b1, 1'b0);
    end
    tick();
    idle_all();
    rst = 1'b1;
    set_b(32'h40, 1'b1, 1'b1, 6'h10, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    idle_all();
    set_b(32'h40, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    #3;
    chk("midrst pred", 32'(b_pred), 32'd0);
    chk("midrst idx",  32'(b_idx),  32'h10);
    chk("midrst ghr",  32'(b_ghr),  32'd0);
    chk("midrst bcnt", b_bc, 32'd0);
    chk("midrst mcnt", b_mc, 32'd0);
    b_pc = 32'h5C;
    #1;
    chk("midrst pred17", 32'(b_pred), 32'd0);
    set_b(32'h40, 1'b1, 1'b1, 6'h10, 1'b1, 1'b0);
    tick();
    idle_all();
    #3;
    chk("midrst retrain pred", 32'(b_pred), 32'd1);
    chk("midrst retrain ghr",  32'(b_ghr),  32'h01);
    chk("midrst retrain bcnt", b_bc, 32'd1);

    // performance counters: 10 updates, 3 mispredicts, 2 stray mispredict flags
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle_all();
      set_b(32'h40, 1'b1, 1'b1, 6'h10, i[0], (i == 0 || i == 4 || i == 8));
      if (i == 5) begin
        #3;
        chk("perf mid bcnt", b_bc, 32'd5);
        chk("perf mid mcnt", b_mc, 32'd2);
      end
      tick();
    end
    idle_all();
    b_um = 1'b1;
    tick();
    tick();
    idle_all();
    #3;
    chk("perf bcnt", b_bc, 32'd10);
    chk("perf mcnt", b_mc, 32'd3);

    // narrow instance: 1-bit counters, HIST_LEN == IDX, 4-bit counter wrap
    s_pc = 4'h4; s_br = 1'b1;
    #1;
    chk("small rst idx",  32'(s_idx),  32'd1);
    chk("small rst pred", 32'(s_pred), 32'd0);
    chk("small rst ghr",  32'(s_ghr),  32'd0);
    for (int i = 0; i < 16; i++) begin
      s_ue = 1'b1; s_ui = 2'd1; s_ut = 1'b1; s_um = i[0];
      if (i == 15) begin
        #3;
        chk("small bcnt15", 32'(s_bc), 32'd15);
        chk("small mcnt15", 32'(s_mc), 32'd7);
      end
      tick();
    end
    idle_all();
    s_pc = 4'h8;
    #3;
    chk("small wrap bcnt", 32'(s_bc), 32'd0);
    chk("small mcnt",      32'(s_mc), 32'd8);
    chk("small ghr",       32'(s_ghr), 32'd3);
    chk("small idx hash",  32'(s_idx), 32'd1);
    chk("small pred sat",  32'(s_pred), 32'd1);
    s_pc = 4'h4;
    #1;
    chk("small idx2",  32'(s_idx),  32'd2);
    chk("small pred2", 32'(s_pred), 32'd0);
    s_ue = 1'b1; s_ui = 2'd1; s_ut = 1'b0;
    tick();
    idle_all();
    s_pc = 4'hC;
    #3;
    chk("small nt ghr",  32'(s_ghr),  32'd2);
    chk("small nt idx",  32'(s_idx),  32'd1);
    chk("small nt pred", 32'(s_pred), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised dynamic branch predictor: a pattern history table (PHT) of saturating counters, indexed by fetch PC, with an optional global-history (gshare) hash. It replaces the single global predictor in the IF stage. It gives a combinational taken/not-taken prediction for a conditional branch in IF. It is trained by the branch resolution in ID, and it keeps branch and mispredict performance counters.

## Interface
Parameters:
- WIDTH, 32: PC width and performance-counter width.
- ENTRIES, 64: number of PHT entries. Power of two, at least 4. IDX = $clog2(ENTRIES).
- CTR_BITS, 2: counter width, 1 to 4.
- HIST_LEN, 6: global history length, 1 ≤ HIST_LEN ≤ IDX.
- GSHARE, 1: 1 selects a gshare index, 0 selects a bimodal index (PC bits only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- IF_pc  in  WIDTH  fetch PC for lookup.
- IF_Branch  in  1  the fetched instruction is a conditional branch.
- prediction  out  1  predicted taken.
- pred_index  out  IDX  PHT index used for this lookup; the pipeline carries it to ID.
- upd_en  in  1  a branch resolves this cycle.
- upd_index  in  IDX  index to train; this is the pred_index captured at lookup.
- upd_taken  in  1  actual branch outcome.
- upd_mispredict  in  1  the resolved outcome differs from the prediction that was carried down.
- ghr  out  HIST_LEN  global history register.
- branch_cnt  out  WIDTH  resolved branches.
- miss_cnt  out  WIDTH  mispredicted branches.

## Operation
- pc_idx = IF_pc[IDX+1:2]. Bits [1:0] are ignored.
- pred_index = GSHARE ? pc_idx ^ {{(IDX-HIST_LEN){1'b0}}, ghr} : pc_idx.
- prediction = IF_Branch & PHT[pred_index][CTR_BITS-1], i.e. the counter MSB. prediction is 0 whenever IF_Branch = 0; pred_index is still driven.
- Counter training on upd_en:
  - upd_taken = 1: PHT[upd_index] increments, saturating at 2^CTR_BITS-1.
  - upd_taken = 0: PHT[upd_index] decrements, saturating at 0.
- History on upd_en: ghr ← {ghr[HIST_LEN-2:0], upd_taken}; for HIST_LEN = 1, ghr ← upd_taken. History is non-speculative (it updates only at resolution). It is maintained even when GSHARE = 0.
- Performance counters:
  - branch_cnt += 1 on upd_en.
  - miss_cnt += 1 on upd_en & upd_mispredict.
  - Both wrap modulo 2^WIDTH.
  - upd_mispredict is ignored when upd_en = 0.
- Reset, after one cycle of rst:
  - Every PHT entry = 2^(CTR_BITS-1)-1 (weakly not-taken; 0 when CTR_BITS = 1).
  - ghr = 0, branch_cnt = 0, miss_cnt = 0.
  - Resulting outputs: prediction = 0, pred_index = pc_idx.
- rst has priority: upd_en asserted during rst has no effect on any state.
- The PHT is a register array (no SRAM macro), so the whole table resets in one cycle.

## Timing
- Lookup is purely combinational from IF_pc, IF_Branch and the registered ghr/PHT. Latency is 0 cycles.
- Update is registered. The new counter, ghr and perf counts are visible the cycle after upd_en.
- Lookup and update in the same cycle, including to the same index, have no bypass. The lookup returns the pre-update counter and uses the pre-update ghr.
- Exactly one update per cycle. Training back-to-back on consecutive cycles to the same index accumulates correctly.
- The block uses the rising edge only; it has no negative-edge state.

## Test plan
Defaults unless stated: ENTRIES=64, CTR_BITS=2, HIST_LEN=6.
- Reset: hold rst 1 cycle, then IF_Branch=1, IF_pc=0x0000_0040 → prediction=0, pred_index=0x10, ghr=0, branch_cnt=0, miss_cnt=0.
- Saturation, GSHARE=0, index 0x10:
  - 1 taken update → counter 2, prediction=1.
  - 3 more taken → counter 3 (saturated).
  - 1 not-taken → counter 2, prediction still 1.
  - 3 more not-taken → counter 0, prediction=0.
  - 1 further not-taken → counter stays 0.
- Gshare hash, GSHARE=1: 3 taken updates to index 0 → ghr=6'b000111. Then IF_pc=0x40 → pred_index=0x17. Then 1 not-taken → ghr=6'b001110 and pred_index=0x1E.
- Same-cycle hazard: counter at 0x17 = 1, lookup of 0x17 with a taken update to 0x17 in the same cycle → prediction=0 that cycle, prediction=1 the next cycle.
- Reset mid-training: trained table (index 0x10 = 3, ghr ≠ 0) plus rst and upd_en=1, upd_taken=1 in the same cycle → next cycle index 0x10 = 1, ghr=0, branch_cnt=0.
- Performance counters:
  - 10 updates, 3 with upd_mispredict=1, and 2 cycles of upd_mispredict=1 with upd_en=0 → branch_cnt=10, miss_cnt=3.
  - With WIDTH=4: 16 updates → branch_cnt wraps to 0.
